// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: step-counter control unit that drives the datapath strobes for
// the fetch sequence (T0..T2), the opcode decode (T3) and register-register ALU execution (T4..T5).
// Optional build macro: ILLEGAL_OPCODE_TRAP_EN. When it is defined, an undefined opcode halts
// the sequencer and sets the sticky illegal_op port. When it is undefined, an undefined opcode
// is treated as nop.
module alu_control_sequencer #(
  parameter int unsigned OPC_W        = 5,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run_req,
  input  logic [31:0] ir,
  input  logic        md_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        MD_read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  alu_op,
  output logic        running,
  output logic        halted,
  output logic        mem_timeout
`ifdef ILLEGAL_OPCODE_TRAP_EN
  ,
  output logic        illegal_op
`endif
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               timeout_set;
  logic [OPC_W-1:0]   opcode;
  logic               is_alu;
  logic               is_halt;
  logic [3:0]         alu_dec;
  logic               unused_ir;

  assign opcode    = ir[31 -: OPC_W];
  // The register fields are decoded downstream by Gra/Grb/Grc; only the opcode is used here.
  assign unused_ir = ^ir[31-OPC_W:0];

  // Opcode decode: the ALU function select and the instruction class
  always_comb begin
    is_alu  = 1'b1;
    alu_dec = 4'b0000;
    case (opcode)
      OPC_W'(5'b00011): alu_dec = 4'b0001;
      OPC_W'(5'b00100): alu_dec = 4'b0010;
      OPC_W'(5'b00101): alu_dec = 4'b0011;
      OPC_W'(5'b00110): alu_dec = 4'b0100;
      OPC_W'(5'b00111): alu_dec = 4'b0101;
      OPC_W'(5'b01000): alu_dec = 4'b0110;
      OPC_W'(5'b01001): alu_dec = 4'b0111;
      OPC_W'(5'b01010): alu_dec = 4'b1000;
      OPC_W'(5'b01011): alu_dec = 4'b1001;
      default:          is_alu  = 1'b0;
    endcase
    is_halt = (opcode == OPC_W'(5'b11011));
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic is_nop;
  logic illegal_set;
  assign is_nop = (opcode == OPC_W'(5'b11010));
`endif

  // Next state, T1 wait counter and Moore strobe decode (T3 also looks at the freshly loaded IR)
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    illegal_set  = 1'b0;
`endif
    PCout   = 1'b0; MARin  = 1'b0; IncPC  = 1'b0; Zlowin = 1'b0;
    Zlowout = 1'b0; PCin   = 1'b0; MD_read = 1'b0; MDRin = 1'b0;
    MDRout  = 1'b0; IRin   = 1'b0; Yin    = 1'b0;
    Gra     = 1'b0; Grb    = 1'b0; Grc    = 1'b0;
    Rin     = 1'b0; Rout   = 1'b0;
    alu_op  = 4'b0000;
    running = 1'b0;
    halted  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_req) state_nxt = S_T0;
      end
      S_T0: begin
        running = 1'b1;
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        alu_op = 4'b0000;
        wait_cnt_nxt = '0;
        state_nxt = S_T1;
      end
      S_T1: begin
        running = 1'b1;
        MD_read = 1'b1; MDRin = 1'b1;
        // PC is reloaded only once, on the first T1 cycle, not on every wait cycle.
        if (wait_cnt == '0) begin
          PCin = 1'b1; Zlowout = 1'b1;
        end
        if (md_ready) begin
          state_nxt = S_T2;
        end else if (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1)) begin
          timeout_set = 1'b1;
          state_nxt   = S_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_T2: begin
        running = 1'b1;
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        running = 1'b1;
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_nxt = S_T4;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end
`ifdef ILLEGAL_OPCODE_TRAP_EN
        else if (!is_nop) begin
          illegal_set = 1'b1;
          state_nxt   = S_HALT;
        end
`endif
        else begin
          state_nxt = run_req ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        running = 1'b1;
        Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1;
        alu_op = alu_dec;
        state_nxt = S_T5;
      end
      S_T5: begin
        running = 1'b1;
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        state_nxt = run_req ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout | timeout_set;
    end
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by clear
  always_ff @(posedge clock) begin
    if (clear) illegal_op <= 1'b0;
    else       illegal_op <= illegal_op | illegal_set;
  end
`endif

endmodule
